// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard stall/flush controller.
//   hz_state_e : controller state (run vs. frozen waiting on a data-memory load)
//   RegIdxW    : architectural register-index width
//   RegX0      : index of the hard-wired zero register, which never creates a hazard
package hazard_pkg;

  localparam int unsigned RegIdxW = 5;
  localparam logic [RegIdxW-1:0] RegX0 = '0;

  typedef enum logic {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard stall controller.
//   ID/EX/MA hazard sources : RS1_ID, RS2_ID, useRS1_ID, useRS2_ID, RD_EX, MemRead_EX,
//                             RegWEn_EX, MemRead_MA, dmemReady, PCSel_EX
//   pipeline enables        : stallPC, stallIFID, flushIFID, flushIDEX, stallEXMA, bubbleMAWB
//   status                  : memTimeout (sticky), stallCycles (saturating)
// master = pipeline side, slave = controller side.
interface hazard_stall_ctrl_if
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic [RegIdxW-1:0] RS1_ID;
  logic [RegIdxW-1:0] RS2_ID;
  logic               useRS1_ID;
  logic               useRS2_ID;
  logic [RegIdxW-1:0] RD_EX;
  logic               MemRead_EX;
  logic               RegWEn_EX;
  logic               MemRead_MA;
  logic               dmemReady;
  logic               PCSel_EX;

  logic               stallPC;
  logic               stallIFID;
  logic               flushIFID;
  logic               flushIDEX;
  logic               stallEXMA;
  logic               bubbleMAWB;
  logic               memTimeout;
  logic [CNT_W-1:0]   stallCycles;

  modport master (
    output RS1_ID, RS2_ID, useRS1_ID, useRS2_ID, RD_EX, MemRead_EX, RegWEn_EX,
           MemRead_MA, dmemReady, PCSel_EX,
    input  stallPC, stallIFID, flushIFID, flushIDEX, stallEXMA, bubbleMAWB,
           memTimeout, stallCycles
  );

  modport slave (
    input  RS1_ID, RS2_ID, useRS1_ID, useRS2_ID, RD_EX, MemRead_EX, RegWEn_EX,
           MemRead_MA, dmemReady, PCSel_EX,
    output stallPC, stallIFID, flushIFID, flushIDEX, stallEXMA, bubbleMAWB,
           memTimeout, stallCycles
  );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   clr   : synchronous clear (wins over inc)
//   inc   : count up by one this cycle unless already at all ones
//   count : current value
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {Width{1'b1}})) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller for hazards a bypass cannot resolve: load-use (one bubble),
// multi-cycle data-memory loads (full freeze with timeout abort) and taken-branch/jump flushes.
//   clk, reset : clock, synchronous active-high reset
//   bus        : hazard sources in, pipeline stall/flush enables and status out
// Control outputs are combinational from the registered state and current inputs.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned CNT_W    = 16
) (
  input logic                clk,
  input logic                reset,
  hazard_stall_ctrl_if.slave bus
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  hz_state_e        state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q;
  logic             timeout_set;

  logic             load_use;
  logic             mem_wait;
  logic             freeze;
  logic             released;
  logic             drop_load;
  logic [CNT_W-1:0] stall_cnt;

  assign load_use = bus.MemRead_EX & bus.RegWEn_EX & (bus.RD_EX != RegX0) &
                    ((bus.useRS1_ID & (bus.RD_EX == bus.RS1_ID)) |
                     (bus.useRS2_ID & (bus.RD_EX == bus.RS2_ID)));
  assign mem_wait = bus.MemRead_MA & ~bus.dmemReady;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_set    = 1'b0;
    freeze         = 1'b0;
    released       = 1'b0;
    drop_load      = 1'b0;
    bus.stallPC    = 1'b0;
    bus.stallIFID  = 1'b0;
    bus.flushIFID  = 1'b0;
    bus.flushIDEX  = 1'b0;
    bus.stallEXMA  = 1'b0;
    bus.bubbleMAWB = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_wait) begin
          freeze     = 1'b1;
          state_d    = StMemWait;
          wait_cnt_d = WaitW'(1);
        end else begin
          released = 1'b1;
        end
      end
      StMemWait: begin
        if (bus.dmemReady) begin
          released   = 1'b1;
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitW'(MAX_WAIT)) begin
          // Give up on the load: let EX/MA advance and write a NOP into MA/WB instead.
          released    = 1'b1;
          drop_load   = 1'b1;
          timeout_set = 1'b1;
          state_d     = StRun;
          wait_cnt_d  = '0;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      default: ;
    endcase

    if (freeze) begin
      bus.stallPC    = 1'b1;
      bus.stallIFID  = 1'b1;
      bus.stallEXMA  = 1'b1;
      bus.bubbleMAWB = 1'b1;
    end else if (released) begin
      // Branch beats load-use: the dependent ID instruction is being discarded anyway.
      if (bus.PCSel_EX) begin
        bus.flushIFID = 1'b1;
        bus.flushIDEX = 1'b1;
      end else if (load_use) begin
        bus.stallPC   = 1'b1;
        bus.stallIFID = 1'b1;
        bus.flushIDEX = 1'b1;
      end
      bus.bubbleMAWB = drop_load;
    end

    if (reset) begin
      bus.stallPC    = 1'b0;
      bus.stallIFID  = 1'b0;
      bus.flushIFID  = 1'b0;
      bus.flushIDEX  = 1'b0;
      bus.stallEXMA  = 1'b0;
      bus.bubbleMAWB = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_q | timeout_set;
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (bus.stallPC),
    .count (stall_cnt)
  );

  // Status is forced low while reset is held, before the first clearing edge lands.
  assign bus.memTimeout  = timeout_q & ~reset;
  assign bus.stallCycles = reset ? '0 : stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (MAX_WAIT=4, CNT_W=4).
module tb_hazard_stall_ctrl;

  localparam int unsigned MaxWait = 4;
  localparam int unsigned CntW    = 4;

  // {stallPC, stallIFID, flushIFID, flushIDEX, stallEXMA, bubbleMAWB}
  localparam logic [5:0] CtlNone = 6'b000000;
  localparam logic [5:0] CtlLu   = 6'b110100;
  localparam logic [5:0] CtlBr   = 6'b001100;
  localparam logic [5:0] CtlFrz  = 6'b110011;
  localparam logic [5:0] CtlTo   = 6'b000001;

  typedef struct {
    logic [5:0] ctl;
    int         cnt;
    logic       to;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  hazard_stall_ctrl_if #(.CNT_W(CntW)) bus ();

  hazard_stall_ctrl #(
    .MAX_WAIT (MaxWait),
    .CNT_W    (CntW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    bus.RS1_ID     = '0;
    bus.RS2_ID     = '0;
    bus.useRS1_ID  = 1'b0;
    bus.useRS2_ID  = 1'b0;
    bus.RD_EX      = '0;
    bus.MemRead_EX = 1'b0;
    bus.RegWEn_EX  = 1'b0;
    bus.MemRead_MA = 1'b0;
    bus.dmemReady  = 1'b0;
    bus.PCSel_EX   = 1'b0;
  endtask

  // EX load writing rd, ID reads rs2 == rd.
  task automatic set_lu(input logic [4:0] rd);
    bus.RD_EX      = rd;
    bus.MemRead_EX = 1'b1;
    bus.RegWEn_EX  = 1'b1;
    bus.RS1_ID     = 5'd3;
    bus.useRS1_ID  = 1'b1;
    bus.RS2_ID     = rd;
    bus.useRS2_ID  = 1'b1;
  endtask

  // Inputs are already applied; record expectations, compare mid-cycle, advance one clock.
  task automatic cyc(input string tag, input logic [5:0] ctl, input int cnt, input logic to);
    exp_t e;
    exp_t got;
    e.ctl = ctl;
    e.cnt = cnt;
    e.to  = to;
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    check_eq({tag, ".ctl"}, 32'({bus.stallPC, bus.stallIFID, bus.flushIFID, bus.flushIDEX,
                                 bus.stallEXMA, bus.bubbleMAWB}), 32'(got.ctl));
    check_eq({tag, ".cnt"}, 32'(bus.stallCycles), 32'(got.cnt));
    check_eq({tag, ".to"}, 32'(bus.memTimeout), 32'(got.to));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clr_in();
    @(posedge clk);
    #1;

    // Reset state
    cyc("rst0", CtlNone, 0, 1'b0);
    cyc("rst1", CtlNone, 0, 1'b0);
    reset = 1'b0;
    cyc("idle", CtlNone, 0, 1'b0);

    // Load-use: one bubble, then clear
    set_lu(5'd5);
    cyc("lu_rs2", CtlLu, 0, 1'b0);
    clr_in();
    cyc("lu_after", CtlNone, 1, 1'b0);
    set_lu(5'd0);
    cyc("lu_x0", CtlNone, 1, 1'b0);
    clr_in();
    bus.RD_EX = 5'd7; bus.MemRead_EX = 1'b1; bus.RegWEn_EX = 1'b1;
    bus.RS1_ID = 5'd7; bus.useRS1_ID = 1'b1; bus.RS2_ID = 5'd9; bus.useRS2_ID = 1'b1;
    cyc("lu_rs1", CtlLu, 1, 1'b0);
    bus.useRS1_ID = 1'b0;
    cyc("lu_nouse", CtlNone, 2, 1'b0);
    bus.useRS1_ID = 1'b1; bus.RegWEn_EX = 1'b0;
    cyc("lu_nowen", CtlNone, 2, 1'b0);
    clr_in();

    // Multi-cycle load: three freeze cycles, release on ready
    reset = 1'b1;
    cyc("rst_mc", CtlNone, 0, 1'b0);
    reset = 1'b0;
    bus.MemRead_MA = 1'b1;
    cyc("mc_frz0", CtlFrz, 0, 1'b0);
    cyc("mc_frz1", CtlFrz, 1, 1'b0);
    cyc("mc_frz2", CtlFrz, 2, 1'b0);
    bus.dmemReady = 1'b1;
    cyc("mc_rdy", CtlNone, 3, 1'b0);
    clr_in();
    cyc("mc_after", CtlNone, 3, 1'b0);

    // Branch beats load-use
    set_lu(5'd5);
    bus.PCSel_EX = 1'b1;
    cyc("br_lu", CtlBr, 3, 1'b0);
    clr_in();
    cyc("br_after", CtlNone, 3, 1'b0);

    // Freeze overrides flush; branch re-evaluated on release
    bus.PCSel_EX = 1'b1; bus.MemRead_MA = 1'b1;
    cyc("frz_br", CtlFrz, 3, 1'b0);
    bus.dmemReady = 1'b1;
    cyc("rel_br", CtlBr, 4, 1'b0);
    clr_in();
    cyc("rel_after", CtlNone, 4, 1'b0);

    // dmemReady without a load is ignored
    bus.dmemReady = 1'b1;
    cyc("rdy_noload", CtlNone, 4, 1'b0);
    clr_in();
    cyc("noload_after", CtlNone, 4, 1'b0);

    // Timeout
    reset = 1'b1;
    cyc("rst_to", CtlNone, 0, 1'b0);
    reset = 1'b0;
    bus.MemRead_MA = 1'b1;
    for (int i = 0; i < 4; i++) cyc("to_frz", CtlFrz, i, 1'b0);
    cyc("to_abort", CtlTo, 4, 1'b0);
    clr_in();
    cyc("to_sticky0", CtlNone, 4, 1'b1);
    cyc("to_sticky1", CtlNone, 4, 1'b1);

    // New wait from RUN, then reset in its second freeze cycle
    bus.MemRead_MA = 1'b1;
    cyc("mw_frz0", CtlFrz, 4, 1'b1);
    cyc("mw_frz1", CtlFrz, 5, 1'b1);
    reset = 1'b1;
    cyc("mw_reset", CtlNone, 0, 1'b0);
    reset = 1'b0;
    clr_in();
    cyc("post_rst", CtlNone, 0, 1'b0);
    bus.MemRead_MA = 1'b1; bus.dmemReady = 1'b1;
    cyc("post_rst_rdy", CtlNone, 0, 1'b0);
    clr_in();

    // Saturation at 15
    set_lu(5'd12);
    for (int i = 0; i < 20; i++) cyc("sat", CtlLu, (i < 15) ? i : 15, 1'b0);
    clr_in();
    cyc("sat_hold", CtlNone, 15, 1'b0);

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
